cache_l1_assoc: RTL and testbench
=================================

Name: cache_l1_assoc

Overview:
- Parametrised set-associative L1 cache; next generation of the direct-mapped L1.
- Sits between the CPU memory stage (P* interface) and the system bus (SYS* interface).
- Write-through, no-write-allocate; configurable ways, sets and block size; tree pseudo-LRU replacement.
- Tag, valid, data and PLRU storage are inferred flop arrays; no SRAM macros.

Parameters:
- DATAWIDTH, 32, word width in bits; the only supported value.
- ADDRWIDTH, 32, byte address width.
- WAYS, 2, associativity; legal values 1, 2 or 4.
- INDEXWIDTH, 5, set index bits; gives 2^INDEXWIDTH sets.
- BLOCKWORDS, 4, words per block; power of two, at least 2.
- COUNTERWIDTH, 64, width of the performance counters.
- Derived localparam: TAGWIDTH = ADDRWIDTH - INDEXWIDTH - log2(BLOCKWORDS) - 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- Pstrobe  in  1  request valid; held high until Pready.
- Prw  in  1  1 = write, 0 = read.
- store_type  in  4  active-low byte write enables for writes.
- Paddr  in  ADDRWIDTH  byte address, word aligned.
- Pdata_in  in  DATAWIDTH  store data.
- stall  in  1  pipeline stall.
- Pready  out  1  request complete.
- Pdata_out  out  DATAWIDTH  load data; zero when Pready is 0.
- SYSstrobe  out  1  bus request; held until SYSready.
- SYSrw  out  1  1 = write, 0 = read.
- SYSaddr  out  ADDRWIDTH  bus word address.
- SYSdata_out  out  DATAWIDTH  bus write data; zero when not writing.
- SYSbe  out  4  active-low byte enables; 4'b0000 on reads.
- SYSready  in  1  bus transfer done; data valid for reads.
- SYSdata_in  in  DATAWIDTH  bus read data.
- L1_access  out  COUNTERWIDTH  accepted request count.
- L1_miss  out  COUNTERWIDTH  lookup miss count.

Behaviour:
- Reset (sync, high): FSM goes to IDLE. All valid bits and PLRU bits clear. Pready, SYSstrobe, SYSrw, SYSaddr, SYSdata_out, Pdata_out and counters go to 0; SYSbe goes to 4'hF.
- Reset mid-operation abandons any bus transfer; SYSstrobe is low the cycle after rst.
- FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE: when Pstrobe=1 and stall=0, latch Paddr, Prw, store_type and Pdata_in, then go to LOOKUP. The processor drops Pstrobe the cycle after Pready; IDLE never re-accepts in that cycle.
- LOOKUP: compare the latched tag against all ways of the set. Hit = valid and tag equal; at most one way hits.
  - Read hit: Pready=1 and Pdata_out = hit word this cycle (2-cycle hit latency from acceptance). PLRU is updated. Next state is IDLE, or RESP if stall=1.
  - Read miss: go to REFILL.
  - Write, hit or miss: go to WRITE. On a hit, the cached word is merged byte-wise under store_type in this cycle and PLRU is updated.
- Victim selection: the lowest-index invalid way; otherwise the PLRU victim.
- REFILL: issue BLOCKWORDS bus reads in ascending order. Word i address = {tag, index, i, 2'b00}.
  - Each read holds SYSstrobe=1, SYSrw=0 until SYSready; SYSdata_in is then written into the victim way, word i.
  - The victim's valid bit clears on entry to REFILL.
  - After the last word: set tag and valid, update PLRU, go to RESP.
- WRITE: SYSstrobe=1, SYSrw=1, SYSaddr = latched address, SYSdata_out = latched data, SYSbe = latched store_type. On SYSready go to RESP.
- RESP: Pready=1 (Pdata_out = requested word for reads). Pready and data are held while stall=1; go to IDLE on the first cycle with stall=0.
- A write miss never allocates and does not touch PLRU.
- PLRU: tree of WAYS-1 bits per set; each bit points away from the most recently used way. For WAYS=1 there is no PLRU storage and the victim is always way 0.
- SYSready seen while SYSstrobe=0 is ignored.

Optional Feature:
- Macro CACHE_L1_PERF_EN.
- When defined: L1_access increments once per accepted request. L1_miss increments once per LOOKUP miss, read or write. Both counters wrap modulo 2^COUNTERWIDTH.
- When undefined: both outputs are constant 0 and no counter flops are built.

Decomposition:
- Package cache_l1_pkg holds:
  - the FSM state enum;
  - bus rw encodings;
  - helper functions for tag, index and offset extraction;
  - derived-width localparams.
- Sub-module plru_tree (parameter WAYS) provides:
  - a combinational victim way from the set's bits;
  - the next-bits value given an accessed way.

Test Plan:
- Cold read of 0x0000_0104 -> 4 bus reads at 0x100, 0x104, 0x108, 0x10C; Pready with the word from 0x104. A repeat read hits with Pready 2 cycles after acceptance and no SYSstrobe.
- Write hit at 0x108, data 0xDEADBEEF, store_type 4'b1100 -> one bus write with SYSbe 4'b1100. A following read returns {old[31:16], 16'hBEEF}.
- Write miss at 0x2000 -> one bus write, no refill. The next read of 0x2000 misses; L1_miss = 2 with the macro defined.
- WAYS=2: fill the same set via 0x000, 0x400, touch 0x000, then read 0x800 -> 0x400's way is evicted and 0x000 still hits.
- stall=1 held 3 cycles during RESP -> Pready and Pdata_out are stable for all stalled cycles; one completion only; L1_access increments once.
- rst asserted during the 2nd refill word -> SYSstrobe is 0 next cycle; a subsequent read of the same block misses and refills all 4 words.

Source files
------------

// File: rtl/cache_l1_pkg.sv
// Shared types and address-field helpers for the set-associative L1 cache.
// Helpers work on a maximum-width address; callers size-cast the result.
package cache_l1_pkg;

  localparam int ADDR_MAX  = 32;
  localparam int BE_W      = 4;
  localparam int BYTE_OFFW = 2;

  typedef logic [ADDR_MAX-1:0] addr_max_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  localparam logic [BE_W-1:0] BE_IDLE = 4'hF;
  localparam logic [BE_W-1:0] BE_READ = 4'h0;

  function automatic addr_max_t field_mask(input int w);
    addr_max_t one;
    one = addr_max_t'(1);
    return (one << w) - one;
  endfunction

  function automatic addr_max_t addr_tag(input addr_max_t a, input int offw, input int idxw);
    return a >> (offw + idxw + BYTE_OFFW);
  endfunction

  function automatic addr_max_t addr_index(input addr_max_t a, input int offw, input int idxw);
    return (a >> (offw + BYTE_OFFW)) & field_mask(idxw);
  endfunction

  function automatic addr_max_t addr_word(input addr_max_t a, input int offw);
    return (a >> BYTE_OFFW) & field_mask(offw);
  endfunction

endpackage

// File: rtl/cache_l1_assoc_plru_tree.sv
// Tree pseudo-LRU for one set: victim from the stored bits, and the bits after an access.
// Purely combinational; each bit points away from the most recently used subtree.
module plru_tree #(
  parameter  int WAYS = 2,
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PW-1:0] bits_i,
  input  logic [WW-1:0] way_i,
  output logic [WW-1:0] victim_o,
  output logic [PW-1:0] bits_o
);

  if (WAYS == 4) begin : g_four
    // bit0 picks the half, bit1 covers ways 0/1, bit2 covers ways 2/3
    always_comb begin
      victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
      bits_o    = bits_i;
      bits_o[0] = ~way_i[1];
      if (way_i[1]) bits_o[2] = ~way_i[0];
      else          bits_o[1] = ~way_i[0];
    end
  end else if (WAYS == 2) begin : g_two
    assign victim_o = bits_i;
    assign bits_o   = ~way_i;
  end else begin : g_one
    assign victim_o = '0;
    assign bits_o   = bits_i ^ PW'(way_i);
  end

endmodule

// File: rtl/cache_l1_assoc.sv
// Write-through, no-write-allocate set-associative L1; 2-cycle read hit, misses refill a block.
// CPU side holds Pready through stall; bus side holds SYSstrobe until SYSready. Counters: CACHE_L1_PERF_EN.
module cache_l1_assoc
  import cache_l1_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int WAYS         = 2,
  parameter int INDEXWIDTH   = 5,
  parameter int BLOCKWORDS   = 4,
  parameter int COUNTERWIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Pstrobe,
  input  logic                    Prw,
  input  logic [3:0]              store_type,
  input  logic [ADDRWIDTH-1:0]    Paddr,
  input  logic [DATAWIDTH-1:0]    Pdata_in,
  input  logic                    stall,
  output logic                    Pready,
  output logic [DATAWIDTH-1:0]    Pdata_out,
  output logic                    SYSstrobe,
  output logic                    SYSrw,
  output logic [ADDRWIDTH-1:0]    SYSaddr,
  output logic [DATAWIDTH-1:0]    SYSdata_out,
  output logic [3:0]              SYSbe,
  input  logic                    SYSready,
  input  logic [DATAWIDTH-1:0]    SYSdata_in,
  output logic [COUNTERWIDTH-1:0] L1_access,
  output logic [COUNTERWIDTH-1:0] L1_miss
);

  localparam int OFFW     = $clog2(BLOCKWORDS);
  localparam int TAGWIDTH = ADDRWIDTH - INDEXWIDTH - OFFW - BYTE_OFFW;
  localparam int SETS     = 1 << INDEXWIDTH;
  localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW       = (WAYS > 1) ? WAYS - 1 : 1;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic                   rw_q;
  logic [3:0]             be_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [OFFW-1:0]        cnt_q;
  logic [WW-1:0]          way_q;
  logic                   done_q;

  logic [WAYS-1:0]        valid_q [SETS];
  logic [TAGWIDTH-1:0]    tag_q   [SETS][WAYS];
  logic [DATAWIDTH-1:0]   data_q  [SETS][WAYS][BLOCKWORDS];

  logic [TAGWIDTH-1:0]    req_tag;
  logic [INDEXWIDTH-1:0]  req_idx;
  logic [OFFW-1:0]        req_word;
  logic                   hit;
  logic [WW-1:0]          hit_way, inv_way, victim, plru_victim, plru_way;
  logic                   inv_found;
  logic [PW-1:0]          plru_bits, plru_next;

  logic accept, hit_upd, wr_merge, refill_wr, refill_done;

  assign req_tag  = TAGWIDTH'(addr_tag(addr_max_t'(addr_q), OFFW, INDEXWIDTH));
  assign req_idx  = INDEXWIDTH'(addr_index(addr_max_t'(addr_q), OFFW, INDEXWIDTH));
  assign req_word = OFFW'(addr_word(addr_max_t'(addr_q), OFFW));

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim = inv_found ? inv_way : plru_victim;
  end

  assign plru_way = (state_q == S_REFILL) ? way_q : hit_way;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_bits),
    .way_i    (plru_way),
    .victim_o (plru_victim),
    .bits_o   (plru_next)
  );

  always_comb begin
    state_d     = state_q;
    Pready      = 1'b0;
    Pdata_out   = '0;
    SYSstrobe   = 1'b0;
    SYSrw       = BUS_READ;
    SYSaddr     = '0;
    SYSdata_out = '0;
    SYSbe       = BE_IDLE;
    accept      = 1'b0;
    hit_upd     = 1'b0;
    wr_merge    = 1'b0;
    refill_wr   = 1'b0;
    refill_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Pstrobe && !stall && !done_q) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (rw_q == BUS_WRITE) begin
          hit_upd  = hit;
          wr_merge = hit;
          state_d  = S_WRITE;
        end else if (hit) begin
          Pready    = 1'b1;
          Pdata_out = data_q[req_idx][hit_way][req_word];
          hit_upd   = 1'b1;
          state_d   = stall ? S_RESP : S_IDLE;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        SYSstrobe = 1'b1;
        SYSaddr   = {req_tag, req_idx, cnt_q, 2'b00};
        SYSbe     = BE_READ;
        if (SYSready) begin
          refill_wr = 1'b1;
          if (cnt_q == OFFW'(BLOCKWORDS - 1)) begin
            refill_done = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_WRITE: begin
        SYSstrobe   = 1'b1;
        SYSrw       = BUS_WRITE;
        SYSaddr     = addr_q;
        SYSdata_out = wdata_q;
        SYSbe       = be_q;
        if (SYSready) state_d = S_RESP;
      end
      S_RESP: begin
        Pready    = 1'b1;
        Pdata_out = rw_q ? '0 : data_q[req_idx][way_q][req_word];
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rw_q    <= BUS_READ;
      be_q    <= BE_IDLE;
      wdata_q <= '0;
      cnt_q   <= '0;
      way_q   <= '0;
      done_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      // Blocks re-acceptance in the cycle right after a completion.
      done_q  <= Pready && (state_d == S_IDLE);
      if (accept) begin
        addr_q  <= Paddr;
        rw_q    <= Prw;
        be_q    <= store_type;
        wdata_q <= Pdata_in;
      end
      if (state_q == S_LOOKUP) begin
        way_q <= hit ? hit_way : victim;
        cnt_q <= '0;
      end
      if (state_q == S_LOOKUP && state_d == S_REFILL) valid_q[req_idx][victim] <= 1'b0;
      if (refill_wr) cnt_q <= cnt_q + OFFW'(1);
      if (refill_done) valid_q[req_idx][way_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_wr) data_q[req_idx][way_q][cnt_q] <= SYSdata_in;
    if (refill_done) tag_q[req_idx][way_q] <= req_tag;
    if (wr_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (!be_q[b]) data_q[req_idx][hit_way][req_word][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  if (WAYS > 1) begin : g_plru
    logic [PW-1:0] plru_q [SETS];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (hit_upd || refill_done) begin
        plru_q[req_idx] <= plru_next;
      end
    end
    assign plru_bits = plru_q[req_idx];
  end else begin : g_no_plru
    assign plru_bits = '0;
  end

`ifdef CACHE_L1_PERF_EN
  logic [COUNTERWIDTH-1:0] access_q, miss_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      access_q <= '0;
      miss_q   <= '0;
    end else begin
      if (accept) access_q <= access_q + COUNTERWIDTH'(1);
      if (state_q == S_LOOKUP && !hit) miss_q <= miss_q + COUNTERWIDTH'(1);
    end
  end
  assign L1_access = access_q;
  assign L1_miss   = miss_q;
`else
  assign L1_access = '0;
  assign L1_miss   = '0;
`endif

endmodule

// File: tb/tb_cache_l1_assoc.sv
// Directed bench for cache_l1_assoc with a byte-enable-aware bus memory responder.
module tb_cache_l1_assoc;

`ifdef CACHE_L1_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Pstrobe, Prw, stall;
  logic [3:0]  store_type;
  logic [31:0] Paddr, Pdata_in;
  logic        Pready;
  logic [31:0] Pdata_out;
  logic        SYSstrobe, SYSrw;
  logic [31:0] SYSaddr, SYSdata_out;
  logic [3:0]  SYSbe;
  logic        SYSready;
  logic [31:0] SYSdata_in;
  logic [63:0] L1_access, L1_miss;

  always #5 clk = ~clk;

  cache_l1_assoc dut (
    .clk(clk), .rst(rst), .Pstrobe(Pstrobe), .Prw(Prw), .store_type(store_type),
    .Paddr(Paddr), .Pdata_in(Pdata_in), .stall(stall), .Pready(Pready),
    .Pdata_out(Pdata_out), .SYSstrobe(SYSstrobe), .SYSrw(SYSrw), .SYSaddr(SYSaddr),
    .SYSdata_out(SYSdata_out), .SYSbe(SYSbe), .SYSready(SYSready),
    .SYSdata_in(SYSdata_in), .L1_access(L1_access), .L1_miss(L1_miss)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  logic [3:0]  rd_be;
  int          n_wr = 0;
  logic [31:0] wr_addr, wr_data, cur;
  logic [3:0]  wr_be;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // One-cycle-latency bus slave; each transfer takes two cycles.
  initial begin
    SYSready   = 1'b0;
    SYSdata_in = '0;
    rd_be      = 4'hF;
    forever begin
      @(negedge clk);
      if (SYSready) begin
        SYSready   = 1'b0;
        SYSdata_in = '0;
      end else if (SYSstrobe) begin
        SYSready = 1'b1;
        if (SYSrw) begin
          n_wr++;
          wr_addr = SYSaddr;
          wr_data = SYSdata_out;
          wr_be   = SYSbe;
          cur     = mem_rd(SYSaddr);
          for (int b = 0; b < 4; b++)
            if (!SYSbe[b]) cur[8*b +: 8] = SYSdata_out[8*b +: 8];
          mem[SYSaddr] = cur;
        end else begin
          rd_log.push_back(SYSaddr);
          rd_be      = SYSbe;
          SYSdata_in = mem_rd(SYSaddr);
        end
      end
    end
  end

  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output int lat);
    @(negedge clk);
    Pstrobe = 1'b1; Prw = rw; Paddr = addr; Pdata_in = wd; store_type = st;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!Pready && lat < 200);
    check_val("pready_seen", Pready, 1'b1);
    rd = Pdata_out;
    Pstrobe = 1'b0; Prw = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_d, input int exp_nrd);
    logic [31:0] rd;
    int lat;
    rd_log.delete();
    do_req(1'b0, addr, 32'h0, 4'hF, rd, lat);
    check_val({tag, "_data"}, rd, exp_d);
    check_val({tag, "_nrd"}, rd_log.size(), exp_nrd);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, cyc, wr0;
    rst = 1'b1; Pstrobe = 1'b0; Prw = 1'b0; store_type = 4'hF;
    Paddr = '0; Pdata_in = '0; stall = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_pready", Pready, 1'b0);
    check_val("rst_strobe", SYSstrobe, 1'b0);
    check_val("rst_sysbe", SYSbe, 4'hF);
    check_val("rst_sysaddr", SYSaddr, 32'h0);
    check_val("rst_sysdout", SYSdata_out, 32'h0);
    check_val("rst_pdout", Pdata_out, 32'h0);
    check_val("rst_access", L1_access, 64'h0);
    rst = 1'b0;

    // Cold read: full block fetched in ascending order.
    read_chk("cold", 32'h104, 32'hC0DE_0104, 4);
    for (int i = 0; i < 4; i++)
      check_val("cold_addr", (rd_log.size() > i) ? rd_log[i] : 32'hX, 32'h100 + 32'(4*i));
    check_val("cold_rd_be", rd_be, 4'h0);

    rd_log.delete();
    do_req(1'b0, 32'h104, 32'h0, 4'hF, rd, lat);
    check_val("hit_data", rd, 32'hC0DE_0104);
    check_val("hit_lat", lat, 2);
    check_val("hit_nrd", rd_log.size(), 0);

    // Write hit: only the low two bytes are enabled (active-low).
    wr0 = n_wr;
    rd_log.delete();
    do_req(1'b1, 32'h108, 32'hDEAD_BEEF, 4'b1100, rd, lat);
    check_val("wh_nwr", n_wr - wr0, 1);
    check_val("wh_addr", wr_addr, 32'h108);
    check_val("wh_data", wr_data, 32'hDEAD_BEEF);
    check_val("wh_be", wr_be, 4'b1100);
    check_val("wh_nrd", rd_log.size(), 0);
    read_chk("wh_rd", 32'h108, 32'hC0DE_BEEF, 0);

    // Write miss: written through, never allocated.
    pulse_rst();
    wr0 = n_wr;
    rd_log.delete();
    do_req(1'b1, 32'h2000, 32'h1234_5678, 4'b0000, rd, lat);
    check_val("wm_nwr", n_wr - wr0, 1);
    check_val("wm_nrd", rd_log.size(), 0);
    read_chk("wm_rd", 32'h2000, 32'h1234_5678, 4);
    check_val("wm_miss", L1_miss, PERF ? 64'd2 : 64'd0);
    check_val("wm_access", L1_access, PERF ? 64'd2 : 64'd0);

    // Stall held through RESP.
    rd_log.delete();
    @(negedge clk);
    Pstrobe = 1'b1; Prw = 1'b0; Paddr = 32'h500; store_type = 4'hF;
    @(negedge clk);
    stall = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!Pready && cyc < 200);
    for (int k = 0; k < 3; k++) begin
      check_val("stall_pready", Pready, 1'b1);
      check_val("stall_data", Pdata_out, 32'hC0DE_0500);
      if (k < 2) @(negedge clk);
    end
    stall = 1'b0; Pstrobe = 1'b0;
    @(negedge clk);
    check_val("stall_done", Pready, 1'b0);
    check_val("stall_pdout", Pdata_out, 32'h0);
    check_val("stall_access", L1_access, PERF ? 64'd3 : 64'd0);
    @(negedge clk);

    // Reset during the second refill word.
    rd_log.delete();
    @(negedge clk);
    Pstrobe = 1'b1; Prw = 1'b0; Paddr = 32'h300; store_type = 4'hF;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (rd_log.size() < 2 && cyc < 200);
    check_val("rr_words_before", rd_log.size(), 2);
    rst = 1'b1; Pstrobe = 1'b0;
    @(negedge clk);
    check_val("rr_strobe", SYSstrobe, 1'b0);
    rst = 1'b0;
    check_val("rr_pready", Pready, 1'b0);
    check_val("rr_miss", L1_miss, 64'h0);
    read_chk("rr_rd", 32'h300, 32'hC0DE_0300, 4);
    check_val("rr_addr0", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'h300);
    check_val("rr_addr3", (rd_log.size() > 3) ? rd_log[3] : 32'hX, 32'h30C);

    // Two-way replacement in set 0.
    pulse_rst();
    read_chk("w_a", 32'h000, 32'hC0DE_0000, 4);
    read_chk("w_b", 32'h400, 32'hC0DE_0400, 4);
    read_chk("w_a_hit", 32'h000, 32'hC0DE_0000, 0);
    read_chk("w_c", 32'h800, 32'hC0DE_0800, 4);
    read_chk("w_a_keep", 32'h000, 32'hC0DE_0000, 0);
    read_chk("w_c_hit", 32'h800, 32'hC0DE_0800, 0);
    read_chk("w_b_gone", 32'h400, 32'hC0DE_0400, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
